// File: rtl/share_fold_pkg.sv
// Shared types and helpers for the share-fold sequencer.
package share_fold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } fold_state_t;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/reduce_xor.sv
// XOR-reduces NUM_ELEMENTS packed elements into a single element.
module reduce_xor #(
    parameter int unsigned NUM_ELEMENTS  = 3,
    parameter int unsigned ELEMENT_WIDTH = 8
) (
    input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] elements,
    output logic [ELEMENT_WIDTH-1:0]              result
);

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            result = result ^ elements[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
    end

endmodule

// File: rtl/share_fold_sequencer.sv
// Captures a packed share array and XOR-folds it CHUNK shares per cycle,
// presenting the result with a valid/ready handshake.
module share_fold_sequencer
    import share_fold_pkg::*;
#(
    parameter int unsigned NUM_SHARES    = 8,
    parameter int unsigned ELEMENT_WIDTH = 8,
    parameter int unsigned CHUNK         = 3
) (
    input  logic                            in_clock,
    input  logic                            in_reset_n,
    input  logic [NUM_SHARES*ELEMENT_WIDTH-1:0] in_shares,
    input  logic                            in_valid,
    output logic                            out_ready,
    output logic [ELEMENT_WIDTH-1:0]        out_xor,
    output logic                            out_valid,
    input  logic                            in_consumer_ready,
    output logic                            out_busy
);

    localparam int unsigned NUM_BEATS = ceil_div(NUM_SHARES, CHUNK);
    localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned SHARES_W  = NUM_SHARES * ELEMENT_WIDTH;
    localparam int unsigned CHUNK_W   = CHUNK * ELEMENT_WIDTH;
    localparam int unsigned PADDED_W  = NUM_BEATS * CHUNK_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    fold_state_t              state;
    logic [BEAT_W-1:0]        beat;
    logic [ELEMENT_WIDTH-1:0] acc;
    logic [ELEMENT_WIDTH-1:0] chunk_xor;
    logic [SHARES_W-1:0]      captured;
    logic [PADDED_W-1:0]      padded;
    logic [CHUNK_W-1:0]       chunk;

    // Zero-extending to a whole number of chunks makes the trailing indices fold as zero.
    assign padded = PADDED_W'(captured);
    assign chunk  = padded[32'(beat) * CHUNK_W +: CHUNK_W];

    reduce_xor #(
        .NUM_ELEMENTS  (CHUNK),
        .ELEMENT_WIDTH (ELEMENT_WIDTH)
    ) u_reduce_xor (
        .elements (chunk),
        .result   (chunk_xor)
    );

    assign out_ready = (state == IDLE) || ((state == DONE) && in_consumer_ready);

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state     <= IDLE;
            beat      <= '0;
            acc       <= '0;
            captured  <= '0;
            out_valid <= 1'b0;
            out_busy  <= 1'b0;
            out_xor   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        captured <= in_shares;
                        acc      <= '0;
                        beat     <= '0;
                        out_busy <= 1'b1;
                        state    <= FOLD;
                    end
                end
                FOLD: begin
                    acc <= acc ^ chunk_xor;
                    if (beat == LAST_BEAT) begin
                        out_xor   <= acc ^ chunk_xor;
                        out_valid <= 1'b1;
                        out_busy  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    if (in_consumer_ready) begin
                        out_valid <= 1'b0;
                        out_xor   <= '0;
                        // A waiting producer is taken on the hand-off edge, skipping IDLE.
                        if (in_valid) begin
                            captured <= in_shares;
                            acc      <= '0;
                            beat     <= '0;
                            out_busy <= 1'b1;
                            state    <= FOLD;
                        end else begin
                            captured <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/share_fold_sequencer.md
SHARE_FOLD_SEQUENCER -- requirements
Module: share_fold_sequencer

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 8: number of shares combined per job.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 8: bit width of one share.
REQ-003 SHALL have parameter CHUNK, default 3: shares folded per cycle; legal range 1..NUM_SHARES.
REQ-004 SHALL have port in_clock, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port in_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_shares, input, NUM_SHARES x ELEMENT_WIDTH: packed share array, element 0 in the LSBs.
REQ-007 SHALL have port in_valid, input, 1 bit: producer offers in_shares.
REQ-008 SHALL have port out_ready, output, 1 bit: block accepts in_shares this cycle.
REQ-009 SHALL have port out_xor, output, ELEMENT_WIDTH: XOR of all captured shares.
REQ-010 SHALL have port out_valid, output, 1 bit: out_xor holds a result.
REQ-011 SHALL have port in_consumer_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port out_busy, output, 1 bit: high in FOLD.

Function
REQ-013 SHALL define NUM_BEATS = ceil(NUM_SHARES/CHUNK).
REQ-014 SHALL implement states IDLE, FOLD and DONE.
REQ-015 SHALL accept a job on a rising edge where in_valid and out_ready are both high.
  - On acceptance: capture in_shares, clear the accumulator, set beat to 0, enter FOLD.
REQ-016 SHALL drive out_ready = (IDLE) or (DONE and in_consumer_ready), combinationally.
REQ-017 SHALL, in each FOLD cycle, XOR captured shares [beat*CHUNK .. beat*CHUNK+CHUNK-1] into the accumulator.
  - Indices at or above NUM_SHARES contribute zero.
REQ-018 SHALL increment beat each FOLD cycle.
  - At beat == NUM_BEATS-1, the edge moves to DONE and the final chunk is included.
REQ-019 SHALL assert out_valid first after the NUM_BEATS-th rising edge following the accepting edge.
  - Latency is NUM_BEATS cycles.
REQ-020 SHALL hold out_valid and out_xor stable in DONE until in_consumer_ready is sampled high.
REQ-021 SHALL, on DONE with in_consumer_ready high and in_valid low, return to IDLE.
REQ-022 SHALL, on DONE with in_consumer_ready high and in_valid high, hand off and accept the new job in the same edge.
  - Next state: FOLD, no idle bubble.
REQ-023 SHALL ignore in_valid while in FOLD.
  - out_ready is low in FOLD, so no data is lost or overwritten.
REQ-024 SHALL drive out_xor to zero whenever out_valid is low.
REQ-025 SHALL zero the captured-share register on the edge leaving DONE without a new acceptance.
REQ-026 SHALL, when CHUNK >= NUM_SHARES (NUM_BEATS = 1), take exactly one FOLD cycle.
REQ-027 SHALL size the beat counter as max(1, ceil(log2(NUM_BEATS))) bits.
  - The counter never wraps past NUM_BEATS-1.

Reset
REQ-028 SHALL, while in_reset_n is low, asynchronously force:
  - state to IDLE;
  - beat, accumulator and captured shares to 0;
  - out_valid, out_busy and out_xor to 0.
  - out_ready is 1.
REQ-029 SHALL, on reset assertion mid-FOLD or mid-DONE, discard the job with no output produced.
REQ-030 SHALL, on the first edge after reset release, accept a job if in_valid is high.

Structure
REQ-031 SHALL place the state enum and a ceil-division function in a shared package, share_fold_pkg.
REQ-032 SHALL fold each chunk with exactly one reduce_xor sub-module instance.
  - NUM_ELEMENTS = CHUNK, ELEMENT_WIDTH = ELEMENT_WIDTH.
  - The chunk is selected by a beat-indexed multiplexer.

Verification
REQ-033 SHALL cover basic fold at defaults, shares 0x01..0x08, consumer always ready.
  - out_valid rises 3 edges after acceptance, out_xor = 0x08.
REQ-034 SHALL cover back-pressure: hold in_consumer_ready low for 5 cycles in DONE.
  - out_xor stays 0x08 and out_valid stays high.
  - out_ready stays low; in_valid pulses are ignored.
REQ-035 SHALL cover back-to-back jobs: second job {0xFF,0,0,0,0,0,0,0} presented during DONE with in_consumer_ready high.
  - Accepted on the same edge as the first hand-off.
  - Next out_xor = 0xFF, 3 edges later.
REQ-036 SHALL cover reset mid-job: assert in_reset_n low during beat 1.
  - All outputs go to 0 immediately and out_ready goes to 1.
  - No out_valid appears after release until a new job is accepted.
REQ-037 SHALL cover parameter corners: CHUNK=1 (latency 8) and CHUNK=8 (latency 1), shares 0xA5 x 7 plus 0x00.
  - out_xor = 0xA5 in both cases.
REQ-038 SHALL cover hygiene: after the result is taken and no new job is accepted.
  - The captured-share register reads zero.
  - out_xor = 0 on the next cycle.
